// File: rtl/nand_logic_pipe_if.sv
// Purpose: operand/result handshake bundle for nand_logic_pipe.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry stalls in opposite directions across the bundle.
// Ports (signals):
//   in_valid/in_ready/in_a/in_b/in_op         operand beat, source -> block
//   out_valid/out_ready/out_res               result beat, block -> consumer
//   out_zero/out_ones/out_par                 reduction flags of out_res
//   op_count                                  saturating count of consumed results
// Modports: master = operand source + result consumer, slave = the pipeline block.
interface nand_logic_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;
  logic             out_ones;
  logic             out_par;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_ones, out_par, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_ones, out_par, op_count
  );
endinterface

// File: rtl/nand_logic_pipe.sv
// Purpose: two-stage bitwise logic unit (8 ops) built purely from NAND terms, with result flags.
// Latency: 2 cycles from accept to out_valid when unstalled; 1 beat/cycle throughput.
// Backpressure: valid/ready both sides, 2-beat capacity; in_ready combinationally follows out_ready.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   bus        nand_logic_pipe_if slave: operand beat in, result beat + flags + op_count out
module nand_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  nand_logic_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOT_A = 3'd0,
    OP_NOT_B = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_XOR   = 3'd6,
    OP_XNOR  = 3'd7
  } op_e;

  // Stage-1 holds every first-level NAND term any op needs, so stage 2
  // is at most two NAND levels deep whichever op is selected.
  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] t1;  // ~(a&b)
    logic [WIDTH-1:0] na;  // ~a
    logic [WIDTH-1:0] nb;  // ~b
    logic [WIDTH-1:0] t2;  // ~(t1&a)
    logic [WIDTH-1:0] t3;  // ~(t1&b)
  } s1_t;

  function automatic logic [WIDTH-1:0] nand_f(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    return ~(x & y);
  endfunction

  logic             s1_valid;
  s1_t              s1_q;
  s1_t              s1_d;
  logic             s2_valid;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ones_q;
  logic             par_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  logic [WIDTH-1:0] t1_in;
  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] nor_v;
  logic [WIDTH-1:0] xor_v;
  logic [WIDTH-1:0] xnor_v;
  logic [WIDTH-1:0] res_d;

  // A stage may move when the stage after it is empty or moving too, so an
  // empty s2 pulls s1 forward even while the consumer is stalled.
  assign s2_adv   = ~s2_valid | bus.out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_fire  = bus.in_valid & s1_adv;
  assign out_fire = s2_valid & bus.out_ready;

  assign t1_in = nand_f(bus.in_a, bus.in_b);

  always_comb begin
    s1_d    = '0;
    s1_d.op = op_e'(bus.in_op);
    s1_d.t1 = t1_in;
    s1_d.na = nand_f(bus.in_a, bus.in_a);
    s1_d.nb = nand_f(bus.in_b, bus.in_b);
    s1_d.t2 = nand_f(t1_in, bus.in_a);
    s1_d.t3 = nand_f(t1_in, bus.in_b);
  end

  always_comb begin
    and_v  = nand_f(s1_q.t1, s1_q.t1);
    or_v   = nand_f(s1_q.na, s1_q.nb);
    nor_v  = nand_f(or_v, or_v);
    xor_v  = nand_f(s1_q.t2, s1_q.t3);
    xnor_v = nand_f(xor_v, xor_v);
    res_d  = '0;
    case (s1_q.op)
      OP_NOT_A: res_d = s1_q.na;
      OP_NOT_B: res_d = s1_q.nb;
      OP_AND:   res_d = and_v;
      OP_OR:    res_d = or_v;
      OP_NAND:  res_d = s1_q.t1;
      OP_NOR:   res_d = nor_v;
      OP_XOR:   res_d = xor_v;
      OP_XNOR:  res_d = xnor_v;
      default:  res_d = '0;
    endcase
  end

  // Stage 1: operand data only loads on a real accept, so idle or
  // refused inputs never disturb the held terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2: result and flags load together so they can never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      ones_q   <= 1'b0;
      par_q    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        res_q  <= res_d;
        zero_q <= ~|res_d;
        ones_q <= &res_d;
        par_q  <= ^res_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_fire && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_res   = res_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_ones  = ones_q;
  assign bus.out_par   = par_q;
  assign bus.op_count  = cnt_q;

endmodule
